// File: rtl/iterator_loop.sv
// Loop stage: drives a start/done child N times, feeding each result back as the next operand.
// Optional watchdog on the child wait is enabled by defining ITER_TIMEOUT_EN.
module iterator_loop #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 8,
  parameter int PULSE_LEN = 3,
  parameter int TIMEOUT   = 255
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Stin,
  input  logic [CNT_WIDTH-1:0] N_in,
  input  logic [WIDTH-1:0]     X_in,
  output logic                 Cstart,
  output logic [WIDTH-1:0]     Cx,
  output logic [CNT_WIDTH-1:0] Cidx,
  input  logic                 Cdone,
  input  logic [WIDTH-1:0]     Cres,
  output logic [WIDTH-1:0]     Res,
  output logic                 Done,
  output logic                 Busy,
  output logic                 Err
);

  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_FINISH} state_t;

  localparam logic [CNT_WIDTH-1:0] PL_LAST = CNT_WIDTH'(PULSE_LEN - 1);

  state_t                 r_state, w_state_nx;
  logic                   r_stin_q, r_cdone_q;
  logic [CNT_WIDTH-1:0]   r_n, w_n_nx;
  logic [WIDTH-1:0]       r_acc, w_acc_nx;
  logic [CNT_WIDTH-1:0]   r_pcnt, w_pcnt_nx;
  logic                   r_cstart, w_cstart_nx;
  logic [WIDTH-1:0]       r_cx, w_cx_nx;
  logic [CNT_WIDTH-1:0]   r_cidx, w_cidx_nx;
  logic [WIDTH-1:0]       r_res, w_res_nx;
  logic                   r_done, w_done_nx;
  logic                   r_busy, w_busy_nx;
  logic                   w_st_ev, w_cd_ev;

`ifdef ITER_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] r_wcnt, w_wcnt_nx;
  logic          r_err, w_err_nx;
`endif

  // Edge registers reset high so a level already present at reset release is not an event.
  assign w_st_ev = Stin & ~r_stin_q;
  assign w_cd_ev = Cdone & ~r_cdone_q;

  always_comb begin
    w_state_nx  = r_state;
    w_n_nx      = r_n;
    w_acc_nx    = r_acc;
    w_pcnt_nx   = r_pcnt;
    w_cstart_nx = r_cstart;
    w_cx_nx     = r_cx;
    w_cidx_nx   = r_cidx;
    w_res_nx    = r_res;
    w_done_nx   = r_done;
    w_busy_nx   = r_busy;
`ifdef ITER_TIMEOUT_EN
    w_wcnt_nx   = r_wcnt;
    w_err_nx    = r_err;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_st_ev) begin
          w_n_nx    = N_in;
          w_acc_nx  = X_in;
          w_done_nx = 1'b0;
          w_busy_nx = 1'b1;
`ifdef ITER_TIMEOUT_EN
          w_err_nx  = 1'b0;
`endif
          if (N_in == '0) begin
            w_state_nx = S_FINISH;
          end else begin
            w_cidx_nx   = '0;
            w_cx_nx     = X_in;
            w_pcnt_nx   = '0;
            w_cstart_nx = 1'b1;
            w_state_nx  = S_LAUNCH;
          end
        end
      end
      S_LAUNCH: begin
        if (r_pcnt == PL_LAST) begin
          w_cstart_nx = 1'b0;
          w_state_nx  = S_WAIT;
`ifdef ITER_TIMEOUT_EN
          w_wcnt_nx   = '0;
`endif
        end else begin
          w_pcnt_nx = r_pcnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (w_cd_ev) begin
          w_acc_nx = Cres;
          if (r_cidx == r_n - 1'b1) begin
            w_state_nx = S_FINISH;
          end else begin
            w_cidx_nx   = r_cidx + 1'b1;
            w_cx_nx     = Cres;
            w_pcnt_nx   = '0;
            w_cstart_nx = 1'b1;
            w_state_nx  = S_LAUNCH;
          end
        end
`ifdef ITER_TIMEOUT_EN
        // Expiry performs the finish actions directly so Done lands TIMEOUT cycles after entry.
        else if (r_wcnt == TO_LAST) begin
          w_res_nx   = r_acc;
          w_done_nx  = 1'b1;
          w_err_nx   = 1'b1;
          w_busy_nx  = 1'b0;
          w_state_nx = S_IDLE;
        end else begin
          w_wcnt_nx = r_wcnt + 1'b1;
        end
`endif
      end
      S_FINISH: begin
        w_res_nx   = r_acc;
        w_done_nx  = 1'b1;
        w_busy_nx  = 1'b0;
        w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state   <= S_IDLE;
      r_stin_q  <= 1'b1;
      r_cdone_q <= 1'b1;
      r_n       <= '0;
      r_acc     <= '0;
      r_pcnt    <= '0;
      r_cstart  <= 1'b0;
      r_cx      <= '0;
      r_cidx    <= '0;
      r_res     <= '0;
      r_done    <= 1'b0;
      r_busy    <= 1'b0;
`ifdef ITER_TIMEOUT_EN
      r_wcnt    <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_state   <= w_state_nx;
      r_stin_q  <= Stin;
      r_cdone_q <= Cdone;
      r_n       <= w_n_nx;
      r_acc     <= w_acc_nx;
      r_pcnt    <= w_pcnt_nx;
      r_cstart  <= w_cstart_nx;
      r_cx      <= w_cx_nx;
      r_cidx    <= w_cidx_nx;
      r_res     <= w_res_nx;
      r_done    <= w_done_nx;
      r_busy    <= w_busy_nx;
`ifdef ITER_TIMEOUT_EN
      r_wcnt    <= w_wcnt_nx;
      r_err     <= w_err_nx;
`endif
    end
  end

  assign Cstart = r_cstart;
  assign Cx     = r_cx;
  assign Cidx   = r_cidx;
  assign Res    = r_res;
  assign Done   = r_done;
  assign Busy   = r_busy;
`ifdef ITER_TIMEOUT_EN
  assign Err    = r_err;
`else
  assign Err    = 1'b0;
`endif

endmodule
